// File: rtl/kernel_nios2_qsys_0_oci_trace_monitor.sv
// rtl/kernel_nios2_qsys_0_oci_trace_monitor.sv - OCI debug-capture trace monitor with show-ahead FIFO
//
// Purpose:
//   Samples the Nios II OCI debug-capture trace (dct_buffer/dct_count) every
//   clock. Each change of dct_count while capturing pushes a {count, buffer}
//   entry into an internal show-ahead FIFO, which the bench drains through a
//   read port. Captures that arrive while the FIFO is full (and not being
//   read in the same cycle) are dropped and counted. Once the bench signals
//   the end of the test and the FIFO has drained, a sticky done flag is raised.
//
// Optional feature:
//   KERNEL_NIOS2_OCI_TB_SEQ_CHECK_EN - when defined, every capture after the
//   first one since reset must carry prev_count + 1 (mod 2^CNT_W). A
//   violation sets the sticky seq_err flag and prints the expected and actual
//   count. When undefined, seq_err is tied to 0 and no checker is built.
//
// Ports:
//   clk            single clock, rising edge
//   reset          asynchronous, active-high reset
//   dct_buffer     OCI debug-capture data            [DCT_W-1:0]
//   dct_count      OCI debug-capture count           [CNT_W-1:0]
//   test_ending    level, bench is winding down
//   test_has_ended level, bench has finished stimulus
//   rd_en          pop head entry (ignored while empty)
//   rd_data        head entry {count, buffer}, valid while rd_valid
//   rd_valid       FIFO not empty
//   fifo_level     entries held                      [$clog2(DEPTH):0]
//   overflow_cnt   saturating count of dropped captures
//   done           sticky end-of-test flag
//   seq_err        sticky count-sequence error

module kernel_nios2_qsys_0_oci_trace_monitor #(
  parameter int DCT_W = 30,
  parameter int CNT_W = 4,
  parameter int DEPTH = 16,
  parameter int OVF_W = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [DCT_W-1:0]         dct_buffer,
  input  logic [CNT_W-1:0]         dct_count,
  input  logic                     test_ending,
  input  logic                     test_has_ended,
  input  logic                     rd_en,
  output logic [CNT_W+DCT_W-1:0]   rd_data,
  output logic                     rd_valid,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic [OVF_W-1:0]         overflow_cnt,
  output logic                     done,
  output logic                     seq_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int EW = CNT_W + DCT_W;

  typedef enum logic [1:0] {
    ST_CAPTURE = 2'd0,
    ST_DRAIN   = 2'd1,
    ST_DONE    = 2'd2
  } state_t;

  state_t            state;
  state_t            state_next;

  logic [CNT_W-1:0]  prev_count;

  logic [EW-1:0]     mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [LW-1:0]     level;

  logic              capture;
  logic              empty;
  logic              full;
  logic              pop;
  logic              push;
  logic              drop;

  // ---------------------------------------------------------------------------
  // Capture detection
  // ---------------------------------------------------------------------------
  // prev_count follows dct_count one cycle late, so a change is visible for
  // exactly the cycle in which the new count first appears.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_count <= '0;
    end else begin
      prev_count <= dct_count;
    end
  end

  // Capture uses the current state, so a change arriving in the same cycle
  // that test_ending first rises is still accepted.
  always_comb begin
    capture = (state == ST_CAPTURE) && (dct_count != prev_count);
  end

  // ---------------------------------------------------------------------------
  // FIFO control
  // ---------------------------------------------------------------------------
  // The level is kept separately from the pointers so that full and empty
  // never alias. When full, a simultaneous pop frees the slot the write uses.
  always_comb begin
    empty = (level == '0);
    full  = (level == LW'(DEPTH));
    pop   = rd_en & ~empty;
    push  = capture & (~full | pop);
    drop  = capture & full & ~pop;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // Storage is intentionally not reset; its contents are don't-care while
  // rd_valid is low.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {dct_count, dct_buffer};
    end
  end

  // Saturating drop counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow_cnt <= '0;
    end else if (drop && (overflow_cnt != {OVF_W{1'b1}})) begin
      overflow_cnt <= overflow_cnt + 1'b1;
    end
  end

  // Show-ahead read: head entry is presented combinationally.
  always_comb begin
    rd_data    = mem[rd_ptr];
    rd_valid   = ~empty;
    fifo_level = level;
  end

  // ---------------------------------------------------------------------------
  // End-of-test state machine
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_CAPTURE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_CAPTURE: begin
        if (test_ending || test_has_ended) begin
          state_next = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // The final pop must have taken effect before done is declared.
        if (test_has_ended && empty && !pop) begin
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        state_next = ST_DONE;
      end
      default: begin
        state_next = ST_CAPTURE;
      end
    endcase
  end

  always_comb begin
    done = (state == ST_DONE);
  end

  // ---------------------------------------------------------------------------
  // Optional count-sequence checker
  // ---------------------------------------------------------------------------
`ifdef KERNEL_NIOS2_OCI_TB_SEQ_CHECK_EN
  logic             seen_capture;
  logic             seq_err_r;
  logic [CNT_W-1:0] expected_count;

  always_comb begin
    expected_count = prev_count + 1'b1;
  end

  // The first capture after reset has no predecessor to compare against.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seen_capture <= 1'b0;
      seq_err_r    <= 1'b0;
    end else if (capture) begin
      seen_capture <= 1'b1;
      if (seen_capture && (dct_count != expected_count)) begin
        seq_err_r <= 1'b1;
        $display("oci_trace_monitor: count sequence error, expected %0d got %0d",
                 expected_count, dct_count);
      end
    end
  end

  always_comb begin
    seq_err = seq_err_r;
  end
`else
  always_comb begin
    seq_err = 1'b0;
  end
`endif

endmodule

// File: tb/tb_kernel_nios2_qsys_0_oci_trace_monitor.sv
// tb/tb_kernel_nios2_qsys_0_oci_trace_monitor.sv - self-checking bench for the OCI trace monitor

module tb_kernel_nios2_qsys_0_oci_trace_monitor;

  localparam int DCT_W = 30;
  localparam int CNT_W = 4;
  localparam int DEPTH = 16;
  localparam int OVF_W = 16;
  localparam int EW    = CNT_W + DCT_W;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [DCT_W-1:0] dct_buffer = '0;
  logic [CNT_W-1:0] dct_count = '0;
  logic             test_ending = 1'b0;
  logic             test_has_ended = 1'b0;
  logic             rd_en = 1'b0;
  logic [EW-1:0]    rd_data;
  logic             rd_valid;
  logic [4:0]       fifo_level;
  logic [OVF_W-1:0] overflow_cnt;
  logic             done;
  logic             seq_err;

  // Small instance used only to observe overflow saturation.
  logic             sat_rd_en = 1'b0;
  logic [EW-1:0]    sat_rd_data;
  logic             sat_rd_valid;
  logic [1:0]       sat_level;
  logic [1:0]       sat_ovf;
  logic             sat_done;
  logic             sat_seq_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  kernel_nios2_qsys_0_oci_trace_monitor #(
    .DCT_W(DCT_W), .CNT_W(CNT_W), .DEPTH(DEPTH), .OVF_W(OVF_W)
  ) dut (
    .clk(clk), .reset(reset), .dct_buffer(dct_buffer), .dct_count(dct_count),
    .test_ending(test_ending), .test_has_ended(test_has_ended), .rd_en(rd_en),
    .rd_data(rd_data), .rd_valid(rd_valid), .fifo_level(fifo_level),
    .overflow_cnt(overflow_cnt), .done(done), .seq_err(seq_err)
  );

  kernel_nios2_qsys_0_oci_trace_monitor #(
    .DCT_W(DCT_W), .CNT_W(CNT_W), .DEPTH(2), .OVF_W(2)
  ) u_sat (
    .clk(clk), .reset(reset), .dct_buffer(dct_buffer), .dct_count(dct_count),
    .test_ending(test_ending), .test_has_ended(test_has_ended), .rd_en(sat_rd_en),
    .rd_data(sat_rd_data), .rd_valid(sat_rd_valid), .fifo_level(sat_level),
    .overflow_cnt(sat_ovf), .done(sat_done), .seq_err(sat_seq_err)
  );

  typedef struct {
    logic [CNT_W-1:0] cnt;
    logic [DCT_W-1:0] buffer;
    logic             rd;
    logic [4:0]       level;
    logic             valid;
    logic [EW-1:0]    data;
  } vec_t;

  vec_t          tbl [7];
  logic [EW-1:0] exp_q [$];
  logic [CNT_W-1:0] cnt;
`ifdef KERNEL_NIOS2_OCI_TB_SEQ_CHECK_EN
  localparam logic SEQ_EXP = 1'b1;
`else
  localparam logic SEQ_EXP = 1'b0;
`endif

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    dct_count = '0;
    dct_buffer = '0;
    test_ending = 1'b0;
    test_has_ended = 1'b0;
    rd_en = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    cnt = '0;
  endtask

  // One cycle with a new count/buffer; outputs settle #1 after the edge.
  task automatic push(input logic [CNT_W-1:0] c, input logic [DCT_W-1:0] b, input logic rd);
    @(negedge clk);
    dct_count = c;
    dct_buffer = b;
    rd_en = rd;
    @(posedge clk);
    #1;
    rd_en = 1'b0;
  endtask

  // Checks the show-ahead head against the scoreboard, then pops it.
  task automatic pop_check(input string name);
    @(negedge clk);
    check({name, " rd_valid"}, 64'(rd_valid), 64'(1));
    if (exp_q.size() == 0) begin
      check({name, " scoreboard"}, 64'(0), 64'(1));
    end else begin
      check({name, " rd_data"}, 64'(rd_data), 64'(exp_q[0]));
      void'(exp_q.pop_front());
    end
    rd_en = 1'b1;
    @(posedge clk);
    #1;
    rd_en = 1'b0;
  endtask

  initial begin
    tbl[0] = '{4'd1, 30'h0AA, 1'b0, 5'd1, 1'b1, {4'd1, 30'h0AA}};
    tbl[1] = '{4'd2, 30'h0BB, 1'b0, 5'd2, 1'b1, {4'd1, 30'h0AA}};
    tbl[2] = '{4'd2, 30'h0BB, 1'b1, 5'd1, 1'b1, {4'd2, 30'h0BB}};
    tbl[3] = '{4'd2, 30'h0BB, 1'b1, 5'd0, 1'b0, '0};
    tbl[4] = '{4'd2, 30'h0BB, 1'b1, 5'd0, 1'b0, '0};
    tbl[5] = '{4'd3, 30'h0CC, 1'b1, 5'd1, 1'b1, {4'd3, 30'h0CC}};
    tbl[6] = '{4'd3, 30'h0CC, 1'b1, 5'd0, 1'b0, '0};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset rd_valid", 64'(rd_valid), 64'(0));
    check("reset fifo_level", 64'(fifo_level), 64'(0));
    check("reset overflow_cnt", 64'(overflow_cnt), 64'(0));
    check("reset done", 64'(done), 64'(0));
    check("reset seq_err", 64'(seq_err), 64'(0));
    @(negedge clk);
    reset = 1'b0;

    // Basic capture, read, empty read/write corner cases
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      dct_count = tbl[i].cnt;
      dct_buffer = tbl[i].buffer;
      rd_en = tbl[i].rd;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d fifo_level", i), 64'(fifo_level), 64'(tbl[i].level));
      check($sformatf("vec%0d rd_valid", i), 64'(rd_valid), 64'(tbl[i].valid));
      if (tbl[i].valid)
        check($sformatf("vec%0d rd_data", i), 64'(rd_data), 64'(tbl[i].data));
      check($sformatf("vec%0d overflow_cnt", i), 64'(overflow_cnt), 64'(0));
      check($sformatf("vec%0d seq_err", i), 64'(seq_err), 64'(0));
    end
    rd_en = 1'b0;

    // Overflow: 18 captures into 16 entries
    do_reset();
    for (int i = 0; i < 18; i++) begin
      cnt = cnt + 1'b1;
      push(cnt, 30'(i + 1), 1'b0);
      if (i < 16) exp_q.push_back({cnt, 30'(i + 1)});
    end
    check("ovf fifo_level", 64'(fifo_level), 64'(16));
    check("ovf overflow_cnt", 64'(overflow_cnt), 64'(2));
    check("sat fifo_level", 64'(sat_level), 64'(2));
    check("sat overflow_cnt", 64'(sat_ovf), 64'(3));
    for (int i = 0; i < 16; i++) pop_check($sformatf("ovf drain%0d", i));
    check("ovf drained level", 64'(fifo_level), 64'(0));

    // Full with simultaneous capture and read
    for (int i = 0; i < 16; i++) begin
      cnt = cnt + 1'b1;
      push(cnt, 30'(32'h40 + i), 1'b0);
      exp_q.push_back({cnt, 30'(32'h40 + i)});
    end
    check("full level", 64'(fifo_level), 64'(16));
    @(negedge clk);
    check("full head before pop", 64'(rd_data), 64'(exp_q[0]));
    void'(exp_q.pop_front());
    cnt = cnt + 1'b1;
    push(cnt, 30'h100, 1'b1);
    exp_q.push_back({cnt, 30'h100});
    check("full simul level", 64'(fifo_level), 64'(16));
    check("full simul overflow_cnt", 64'(overflow_cnt), 64'(2));
    for (int i = 0; i < 16; i++) pop_check($sformatf("full drain%0d", i));
    check("full drained valid", 64'(rd_valid), 64'(0));

    // End of test
    do_reset();
    for (int i = 1; i <= 3; i++) begin
      push(4'(i), 30'(i), 1'b0);
      exp_q.push_back({4'(i), 30'(i)});
    end
    @(negedge clk);
    test_ending = 1'b1;
    dct_count = 4'd4;
    dct_buffer = 30'h4;
    exp_q.push_back({4'd4, 30'h4});
    @(posedge clk);
    #1;
    check("eot same-cycle capture level", 64'(fifo_level), 64'(4));
    push(4'd5, 30'h5, 1'b0);
    push(4'd6, 30'h6, 1'b0);
    check("eot no capture in drain", 64'(fifo_level), 64'(4));
    check("eot done early", 64'(done), 64'(0));
    @(negedge clk);
    test_has_ended = 1'b1;
    for (int i = 0; i < 4; i++) pop_check($sformatf("eot pop%0d", i));
    check("eot done after last pop", 64'(done), 64'(0));
    @(posedge clk);
    #1;
    check("eot done rises", 64'(done), 64'(1));
    repeat (3) @(posedge clk);
    #1;
    check("eot done sticky", 64'(done), 64'(1));

    // Reset mid-run in DRAIN with 5 entries and 3 drops
    do_reset();
    for (int i = 0; i < 19; i++) begin
      cnt = cnt + 1'b1;
      push(cnt, 30'(32'h200 + i), 1'b0);
      if (i < 16) exp_q.push_back({cnt, 30'(32'h200 + i)});
    end
    for (int i = 0; i < 11; i++) pop_check($sformatf("rst pop%0d", i));
    @(negedge clk);
    test_ending = 1'b1;
    @(posedge clk);
    #1;
    check("rst pre level", 64'(fifo_level), 64'(5));
    check("rst pre overflow_cnt", 64'(overflow_cnt), 64'(3));
    #1;
    test_ending = 1'b0;
    dct_count = '0;
    reset = 1'b1;
    #1;
    check("rst async rd_valid", 64'(rd_valid), 64'(0));
    check("rst async fifo_level", 64'(fifo_level), 64'(0));
    check("rst async overflow_cnt", 64'(overflow_cnt), 64'(0));
    check("rst async done", 64'(done), 64'(0));
    check("rst async seq_err", 64'(seq_err), 64'(0));
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    push(4'd5, 30'h55, 1'b0);
    exp_q.push_back({4'd5, 30'h55});
    check("rst recapture level", 64'(fifo_level), 64'(1));
    pop_check("rst recapture");

    // Sequence check: 1, 2, 4
    do_reset();
    push(4'd1, 30'h1, 1'b0);
    push(4'd2, 30'h2, 1'b0);
    check("seq after 1,2", 64'(seq_err), 64'(0));
    push(4'd4, 30'h4, 1'b0);
    check("seq after 4", 64'(seq_err), 64'(SEQ_EXP));
    push(4'd5, 30'h5, 1'b0);
    check("seq sticky", 64'(seq_err), 64'(SEQ_EXP));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/kernel_nios2_qsys_0_oci_trace_monitor.md
# kernel_nios2_qsys_0_oci_trace_monitor

Parametrised simulation-side monitor for the Nios II OCI debug-capture trace (DCT) path. It samples `dct_buffer`/`dct_count` every clock, pushes a tagged entry into an internal show-ahead FIFO whenever `dct_count` changes, and lets the bench drain entries through a read port. It tracks dropped entries and signals end-of-test once the FIFO has drained. It sits beside the OCI core in the kernel simulation submodules and replaces the passive test-bench stub with a checkable trace capture.

## Interface
Parameters:
- `DCT_W`, 30, width of `dct_buffer`.
- `CNT_W`, 4, width of `dct_count`.
- `DEPTH`, 16, FIFO entries; power of two, at least 2.
- `OVF_W`, 16, width of the saturating overflow counter.

Ports:
- `clk`  in  1  single clock; all logic is on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `dct_buffer`  in  DCT_W  OCI debug-capture data.
- `dct_count`  in  CNT_W  OCI debug-capture count.
- `test_ending`  in  1  level; the bench is winding down.
- `test_has_ended`  in  1  level; the bench has finished stimulus.
- `rd_en`  in  1  pops the head entry when `rd_valid` is 1.
- `rd_data`  out  CNT_W+DCT_W  head entry, `{count, buffer}`.
- `rd_valid`  out  1  FIFO is not empty.
- `fifo_level`  out  $clog2(DEPTH)+1  number of entries held.
- `overflow_cnt`  out  OVF_W  count of dropped captures; saturates.
- `done`  out  1  sticky end-of-test flag.
- `seq_err`  out  1  sticky count-sequence error (see Configuration).

## Operation
- `prev_count` register: updated every cycle to `dct_count`; reset value 0.
- Capture event: state is CAPTURE and `dct_count != prev_count`.
- State machine (2 bits, reset to CAPTURE):
  - CAPTURE -> DRAIN when `test_ending | test_has_ended`.
  - DRAIN -> DONE when `test_has_ended` and `fifo_level == 0`, with no pop in that cycle.
  - DONE holds until reset.
- A capture event in the same cycle that `test_ending` first rises is still accepted. No captures occur in DRAIN or DONE.
- `done` is 1 only in DONE.
- FIFO behaviour:
  - Write on a capture event. Read on `rd_en & rd_valid`.
  - `rd_en` while empty is ignored, with no underflow.
- FIFO boundary conditions:
  - Full with simultaneous write and read: both succeed and the level is unchanged.
  - Full with a write and no read: the entry is dropped, `overflow_cnt` increments, and the count saturates at all-ones.
  - Empty with simultaneous write and read: the read is ignored and the write succeeds, giving level 1.
- Pointers wrap modulo DEPTH. The level is tracked separately, so full and empty are unambiguous.
- Reset mid-operation, asynchronously:
  - The FIFO is emptied and `overflow_cnt` is cleared to 0.
  - `done` and `seq_err` go to 0 and the state returns to CAPTURE.
  - Stored data is not cleared; it is don't-care while `rd_valid` is 0.

## Timing
- Reset values:
  - `rd_valid` 0, `fifo_level` 0, `overflow_cnt` 0, `done` 0, `seq_err` 0.
  - `rd_data` undefined; the bench must gate it with `rd_valid`.
- Capture latency:
  - A change on `dct_count` at edge N is detected in cycle N.
  - The entry is written at edge N+1, and `rd_valid`/`fifo_level` update after edge N+1.
- Show-ahead read: `rd_data` is valid combinationally from the head whenever `rd_valid` is 1. A pop at edge K presents the next entry after edge K.
- `done` rises one cycle after the DRAIN exit condition is met.

## Configuration
- Macro: `KERNEL_NIOS2_OCI_TB_SEQ_CHECK_EN`.
- Defined:
  - On each capture event except the first after reset, `seq_err` is set if `dct_count != prev_count + 1 (mod 2^CNT_W)`.
  - `seq_err` is sticky, and `$display` prints the expected and actual count.
- Undefined: `seq_err` is tied to 0 and no checking logic is built.

## Test plan
- Basic capture:
  - Stimulus: after reset, set `dct_count` to 1 then 2 on consecutive cycles, with `dct_buffer` 0x0000_0AA then 0x0000_0BB.
  - Response: `fifo_level` goes 1 then 2; `rd_data` reads {1,0x0AA} then {2,0x0BB}; `overflow_cnt` stays 0.
- Overflow:
  - Stimulus: 18 count changes with no reads, DEPTH=16.
  - Response: `fifo_level` is 16 and `overflow_cnt` is 2; draining returns the first 16 entries in order.
- Full, simultaneous:
  - Stimulus: with the FIFO full, apply a capture event and `rd_en` in the same cycle.
  - Response: `fifo_level` stays 16, `overflow_cnt` is unchanged, and the new entry becomes the tail.
- End of test:
  - Stimulus: raise `test_ending` with 3 entries held, keep changing `dct_count`, then raise `test_has_ended` and pop 3.
  - Response: no new entries are captured; `done` is 1 one cycle after the last pop and stays 1.
- Reset mid-run:
  - Stimulus: assert `reset` for one cycle in DRAIN with 5 entries held and `overflow_cnt` at 3.
  - Response: all outputs take their reset values immediately (asynchronously); the next count change is captured.
- Sequence check (macro defined):
  - Stimulus: counts 1, 2, 4.
  - Response: `seq_err` rises after the capture of 4 and stays 1; with the macro undefined, `seq_err` stays 0.
